// File: rtl/mem_wait_stage_n.sv
// Memory-wait pipeline stage: holds an issue group until the data-SRAM response
// for its load lane arrives, and absorbs responses orphaned by flushes.
module mem_wait_stage_n #(
  parameter int LANES      = 2,
  parameter int BUS_WD     = 128,
  parameter int MAX_CANCEL = 3,
  localparam int CW        = $clog2(MAX_CANCEL + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*BUS_WD-1:0]   in_bus,
  input  logic [LANES-1:0]          in_req,
  input  logic [LANES-1:0]          in_older,
  output logic                      allowin,
  input  logic                      out_allowin,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*BUS_WD-1:0]   out_bus,
  output logic [31:0]               out_rdata,
  input  logic                      data_ok,
  input  logic [31:0]               rdata,
  input  logic                      flush,
  input  logic                      stall,
  output logic [LANES-1:0]          fwd_valid,
  output logic [CW-1:0]             cancel_cnt,
  output logic [1:0]                dbg_state_o
);

  // Handshake: a group moves upstream->here when allowin is high at the clock
  // edge (in_valid qualifies lanes); it moves here->downstream when a lane's
  // out_valid and out_allowin are both high at the edge.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [LANES-1:0]          valid_q, valid_d;
  logic [LANES-1:0]          req_q, req_d;
  logic [LANES-1:0]          older_q, older_d;
  logic [LANES-1:0]          fwd_q;
  logic [LANES*BUS_WD-1:0]   bus_q, bus_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [CW-1:0]             cancel_q, cancel_d;

  logic empty, req_live, cancel_zero, cancel_room;
  logic data_hit, ready_go, leave, cnt_inc, cnt_dec;

  assign empty       = ~|valid_q;
  assign req_live    = |(valid_q & req_q);
  assign cancel_zero = (cancel_q == '0);
  assign cancel_room = (cancel_q < CW'(MAX_CANCEL));
  // A response belongs to the waiting load only once every orphan is drained.
  assign data_hit    = data_ok & cancel_zero & (state_q == ST_WAIT);
  assign ready_go    = empty | (~stall & (~req_live | (state_q == ST_HOLD) | data_hit));
  assign allowin     = (empty | (ready_go & out_allowin)) & cancel_room;
  assign leave       = ~empty & ready_go & out_allowin;

  assign out_valid   = valid_q & {LANES{ready_go}} & ~({LANES{flush}} & ~older_q);
  assign out_bus     = bus_q;
  assign out_rdata   = data_hit ? rdata : rdata_q;
  assign fwd_valid   = fwd_q;
  assign cancel_cnt  = cancel_q;
  assign dbg_state_o = state_q;

  // A flushed load whose response is still in flight becomes an orphan.
  assign cnt_inc = flush & (state_q == ST_WAIT) & (|(valid_q & req_q & ~older_q))
                   & ~data_hit & cancel_room;
  assign cnt_dec = data_ok & ~cancel_zero;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    req_d    = req_q;
    older_d  = older_q;
    bus_d    = bus_q;
    rdata_d  = rdata_q;
    cancel_d = cancel_q;

    case ({cnt_inc, cnt_dec})
      2'b10:   cancel_d = cancel_q + CW'(1);
      2'b01:   cancel_d = cancel_q - CW'(1);
      default: cancel_d = cancel_q;
    endcase

    if (flush) begin
      valid_d = leave ? '0 : (valid_q & older_q);
      if (~|(valid_d & req_q)) begin
        state_d = ST_IDLE;
      end else if (data_hit) begin
        state_d = ST_HOLD;
        rdata_d = rdata;
      end
    end else if (allowin) begin
      valid_d = in_valid;
      req_d   = in_req & in_valid;
      older_d = in_older;
      for (int i = 0; i < LANES; i++) begin
        bus_d[i*BUS_WD +: BUS_WD] = in_valid[i] ? in_bus[i*BUS_WD +: BUS_WD] : '0;
      end
      state_d = (|(in_valid & in_req)) ? ST_WAIT : ST_IDLE;
    end else if (leave) begin
      valid_d = '0;
      state_d = ST_IDLE;
    end else if (data_hit) begin
      state_d = ST_HOLD;
      rdata_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      req_q    <= '0;
      older_q  <= '0;
      fwd_q    <= '0;
      bus_q    <= '0;
      rdata_q  <= '0;
      cancel_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      older_q  <= older_d;
      fwd_q    <= valid_d;
      bus_q    <= bus_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

endmodule

// File: tb/tb_mem_wait_stage_n.sv
// Bench for mem_wait_stage_n: table-driven load groups plus hand-written
// flush, orphan-count and reset sequences, with a scoreboard on the output handoff.
module tb_mem_wait_stage_n;

  localparam int LANES = 2;
  localparam int BW    = 16;
  localparam int W     = 67;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [LANES-1:0]        in_valid, in_req, in_older;
  logic [LANES*BW-1:0]     in_bus;
  logic                    allowin, out_allowin;
  logic [LANES-1:0]        out_valid, fwd_valid;
  logic [LANES*BW-1:0]     out_bus;
  logic [31:0]             out_rdata, rdata;
  logic                    data_ok, flush, stall;
  logic [1:0]              cancel_cnt;
  logic [1:0]              dbg_state;

  mem_wait_stage_n #(.LANES(LANES), .BUS_WD(BW), .MAX_CANCEL(3)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_bus(in_bus),
    .in_req(in_req), .in_older(in_older), .allowin(allowin),
    .out_allowin(out_allowin), .out_valid(out_valid), .out_bus(out_bus),
    .out_rdata(out_rdata), .data_ok(data_ok), .rdata(rdata), .flush(flush),
    .stall(stall), .fwd_valid(fwd_valid), .cancel_cnt(cancel_cnt),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {chk_rdata, out_valid[1:0], out_bus[31:0], rdata[31:0]}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    logic [W-1:0] e;
    logic [31:0]  m;
    if (resetn && out_valid != 2'b00 && out_allowin) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got out_valid=%b required no output", out_valid);
      end else begin
        e = exp_q.pop_front();
        m = {{16{e[65]}}, {16{e[64]}}};
        check("sb_valid", 64'(out_valid), 64'(e[65:64]));
        check("sb_bus", 64'(out_bus & m), 64'(e[63:32] & m));
        if (e[66]) check("sb_rdata", 64'(out_rdata), 64'(e[31:0]));
      end
    end
  endtask

  // driver helpers: inputs change at posedge+1, outputs sampled at negedge
  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    commit();
  endtask

  task automatic load(input logic [1:0] v, input logic [1:0] r, input logic [1:0] o);
    in_valid = v;
    in_req   = r;
    in_older = o;
    in_bus   = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    sample();
    check("load_allowin", 64'(allowin), 64'd1);
    commit();
    in_valid = '0;
    in_req   = '0;
    in_older = '0;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  req;
    int          dly;
    int          hold;
    bit          use_stall;
    logic [31:0] rdata;
    logic [1:0]  exp_out;
  } vec_t;

  vec_t        vecs[8];
  vec_t        v;
  logic [31:0] exp_bus;
  logic        has_req;

  initial begin
    vecs[0] = '{2'b11, 2'b01, 2, 0, 1'b0, 32'hDEADBEEF, 2'b11};
    vecs[1] = '{2'b11, 2'b01, 1, 2, 1'b0, 32'hDEADBEEF, 2'b11};
    vecs[2] = '{2'b10, 2'b10, 0, 0, 1'b0, 32'h12345678, 2'b10};
    vecs[3] = '{2'b01, 2'b00, 0, 0, 1'b0, 32'h0,        2'b01};
    vecs[4] = '{2'b11, 2'b00, 0, 0, 1'b0, 32'h0,        2'b11};
    vecs[5] = '{2'b01, 2'b10, 0, 0, 1'b0, 32'h0,        2'b01};
    vecs[6] = '{2'b10, 2'b10, 1, 0, 1'b1, 32'hCAFEF00D, 2'b10};
    vecs[7] = '{2'b11, 2'b10, 3, 1, 1'b0, 32'hA5A55A5A, 2'b11};

    resetn = 1'b0; in_valid = '0; in_req = '0; in_older = '0; in_bus = '0;
    out_allowin = 1'b1; data_ok = 1'b0; rdata = '0; flush = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_out_rdata", 64'(out_rdata), 64'd0);
    check("rst_cancel", 64'(cancel_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_allowin", 64'(allowin), 64'd1);
    commit();
    resetn = 1'b1;
    commit();

    // table-driven groups
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      in_valid = v.valid;
      in_req   = v.req;
      in_older = '0;
      in_bus   = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      exp_bus  = {in_bus[31:16] & {16{v.valid[1]}}, in_bus[15:0] & {16{v.valid[0]}}};
      has_req  = |(v.valid & v.req);
      exp_q.push_back({has_req, v.exp_out, exp_bus, v.rdata});
      sample();
      check("vec_allowin", 64'(allowin), 64'd1);
      commit();
      in_valid = '0;
      in_req   = '0;
      if (has_req) begin
        for (int k = 0; k < v.dly; k++) begin
          sample();
          check("wait_no_out", 64'(out_valid), 64'd0);
          check("wait_fwd", 64'(fwd_valid), 64'(v.valid));
          check("wait_bus", 64'(out_bus), 64'(exp_bus));
          check("wait_state", 64'(dbg_state), 64'(S_WAIT));
          commit();
        end
        data_ok = 1'b1;
        rdata   = v.rdata;
        if (v.use_stall) begin
          stall = 1'b1;
          sample();
          check("stall_no_out", 64'(out_valid), 64'd0);
          commit();
          stall = 1'b0; data_ok = 1'b0; rdata = $urandom;
          sample();
          check("stall_hold_state", 64'(dbg_state), 64'(S_HOLD));
          check("stall_hold_rdata", 64'(out_rdata), 64'(v.rdata));
          commit();
        end else if (v.hold > 0) begin
          out_allowin = 1'b0;
          step();
          data_ok = 1'b0; rdata = $urandom;
          for (int k = 0; k < v.hold; k++) begin
            sample();
            check("hold_state", 64'(dbg_state), 64'(S_HOLD));
            check("hold_valid", 64'(out_valid), 64'(v.exp_out));
            check("hold_rdata", 64'(out_rdata), 64'(v.rdata));
            commit();
          end
          out_allowin = 1'b1;
          step();
        end else begin
          sample();
          check("bypass_valid", 64'(out_valid), 64'(v.exp_out));
          commit();
          data_ok = 1'b0;
        end
      end else begin
        sample();
        check("noreq_bus", 64'(out_bus), 64'(exp_bus));
        check("noreq_fwd", 64'(fwd_valid), 64'(v.valid));
        commit();
      end
    end

    // flush in WAIT with an older lane surviving, then the orphan response
    in_bus = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    exp_q.push_back({1'b0, 2'b10, in_bus, 32'h0});
    in_valid = 2'b11; in_req = 2'b01; in_older = 2'b10;
    sample(); commit();
    in_valid = '0; in_req = '0; in_older = '0;
    step();
    flush = 1'b1;
    sample();
    check("flushA_no_out", 64'(out_valid), 64'd0);
    commit();
    flush = 1'b0;
    sample();
    check("flushA_cancel", 64'(cancel_cnt), 64'd1);
    check("flushA_fwd", 64'(fwd_valid), 64'b10);
    check("flushA_state", 64'(dbg_state), 64'(S_IDLE));
    check("flushA_valid", 64'(out_valid), 64'b10);
    commit();
    data_ok = 1'b1; rdata = 32'h11111111;
    sample();
    check("orphan_no_out", 64'(out_valid), 64'd0);
    commit();
    data_ok = 1'b0;
    sample();
    check("orphan_cancel", 64'(cancel_cnt), 64'd0);
    commit();

    // three flushed loads saturate the orphan counter
    for (int k = 0; k < 3; k++) begin
      load(2'b01, 2'b01, 2'b00);
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    sample();
    check("sat_cancel", 64'(cancel_cnt), 64'd3);
    check("sat_allowin", 64'(allowin), 64'd0);
    commit();
    in_valid = 2'b01; in_req = 2'b00;
    step();
    in_valid = '0;
    sample();
    check("sat_no_load", 64'(out_valid), 64'd0);
    commit();
    data_ok = 1'b1;
    step();
    data_ok = 1'b0;
    sample();
    check("sat_dec_cancel", 64'(cancel_cnt), 64'd2);
    check("sat_dec_allowin", 64'(allowin), 64'd1);
    commit();
    data_ok = 1'b1;
    step(); step();
    data_ok = 1'b0;
    sample();
    check("sat_drain", 64'(cancel_cnt), 64'd0);
    commit();

    // flush and the waited-for response in the same cycle
    load(2'b01, 2'b01, 2'b00);
    flush = 1'b1; data_ok = 1'b1; rdata = 32'h77777777;
    sample();
    check("same_no_out", 64'(out_valid), 64'd0);
    commit();
    flush = 1'b0; data_ok = 1'b0;
    sample();
    check("same_cancel", 64'(cancel_cnt), 64'd0);
    check("same_state", 64'(dbg_state), 64'(S_IDLE));
    commit();

    // flush and an orphan response together leave the count unchanged
    load(2'b01, 2'b01, 2'b00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    load(2'b01, 2'b01, 2'b00);
    flush = 1'b1; data_ok = 1'b1;
    step();
    flush = 1'b0; data_ok = 1'b0;
    sample();
    check("both_cancel", 64'(cancel_cnt), 64'd1);
    check("both_state", 64'(dbg_state), 64'(S_IDLE));
    commit();

    // reset in the middle of WAIT
    load(2'b11, 2'b01, 2'b00);
    step();
    #2 resetn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_fwd", 64'(fwd_valid), 64'd0);
    check("arst_bus", 64'(out_bus), 64'd0);
    check("arst_rdata", 64'(out_rdata), 64'd0);
    check("arst_cancel", 64'(cancel_cnt), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(S_IDLE));
    commit();
    resetn = 1'b1;
    data_ok = 1'b1; rdata = 32'h99999999;
    step();
    data_ok = 1'b0;
    sample();
    check("post_rst_cancel", 64'(cancel_cnt), 64'd0);
    check("post_rst_no_out", 64'(out_valid), 64'd0);
    commit();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
